uart_tx_arbiter: RTL and testbench

//   Shares one UART transmitter (byte2send/tx_start/tx_done, 9600 baud, clk = 2x baud) among
//   N_REQ requesters. Round-robin selection; latches the winner's byte; sequences the

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ clients.
// Optional WAIT-state watchdog is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         byte2send,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               busy,
`ifdef UART_ARB_TIMEOUT_EN
    output logic               timeout_err,
`endif
    output logic [1:0]         dbg_state_o
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshake: req[i] is a level held until gnt[i]; gnt/done/tx_start are
    // single-cycle pulses; tx_done is sampled only while in S_WAIT.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   pick;
    logic [IDXW-1:0]   cand;
    logic              pick_vld;
    logic [7:0]        byte_q, byte_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNTW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IDXW'((int'(ptr_q) + i) % N_REQ);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        byte_d     = byte_q;
        gnt_d      = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = '0;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d     = S_START;
                    idx_d       = pick;
                    byte_d      = req_data[8*pick +: 8];
                    tx_start_d  = 1'b1;
                    gnt_d[pick] = 1'b1;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    state_d       = S_RELEASE;
                    done_d[idx_q] = 1'b1;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNTW'(TIMEOUT_CYC - 1)) begin
                    state_d = S_RELEASE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                ptr_d   = idx_q;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            ptr_q      <= IDXW'(N_REQ - 1);
            byte_q     <= 8'h00;
            gnt_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            byte_q     <= byte_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign byte2send   = byte_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scenario tasks against a round-robin reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N      = 4;
    localparam int BUDGET = 200;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic           tx_done = 1'b0;
    logic [N-1:0]   gnt, done;
    logic [7:0]     byte2send;
    logic           tx_start, busy;
    logic [1:0]     dbg_state;
`ifdef UART_ARB_TIMEOUT_EN
    logic           timeout_err;
`endif

    int checks = 0;
    int errors = 0;
    int gnt_cnt = 0;
    int done_cnt = 0;
    int last_win = N - 1;
    logic [7:0] exp_q[$];

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .byte2send   (byte2send),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .busy        (busy),
`ifdef UART_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (|gnt) gnt_cnt++;
            if (|done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the requester after the last winner (cyclically) is served first.
    function automatic int model_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++)
            if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic wait_start(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (tx_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (|done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        int n, d0;
        @(negedge clk);
        checks++;
        if ({gnt, done, byte2send, tx_start, busy, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_por: got %h want 0", {gnt, done, byte2send, tx_start, busy, dbg_state});
        end
        @(negedge clk) rst_n = 1'b1;
        req_data[23:16] = 8'h5C;
        @(posedge clk); #1 req = 4'b0100;
        wait_start(ok, n);
        req = '0;
        checks++;
        if (!ok || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL reset_pre_frame: ok=%0d gnt=%b want 0100", ok, gnt);
        end
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, byte2send, tx_start, busy, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: got %h want 0", {gnt, done, byte2send, tx_start, busy, dbg_state});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_win = N - 1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0 || dbg_state !== 2'd0 || done_cnt != d0) begin
            errors++;
            $display("FAIL reset_release: busy=%b start=%b state=%0d dones=%0d want 0,0,0,0",
                     busy, tx_start, dbg_state, done_cnt - d0);
        end
`ifdef UART_ARB_TIMEOUT_EN
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
        end
`endif
    endtask

    task automatic test_single();
        bit ok;
        int n;
        req_data[7:0] = 8'h9A;
        exp_q.push_back(8'h9A);
        @(posedge clk); #1 req = 4'b0001;
        wait_start(ok, n);
        req = '0;
        checks++;
        if (!ok || n != 2) begin
            errors++;
            $display("FAIL single_latency: ok=%0d cycles=%0d want 2", ok, n);
        end
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b busy=%b want 0001,1", gnt, busy);
        end
        checks++;
        if (byte2send !== exp_q[0]) begin
            errors++;
            $display("FAIL single_byte: got %h want %h", byte2send, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(posedge clk); #1 tx_done = 1'b1;
        wait_done(ok, n);
        checks++;
        if (!ok || n != 2 || done !== 4'b0001) begin
            errors++;
            $display("FAIL single_done: ok=%0d cycles=%0d done=%b want 2,0001", ok, n, done);
        end
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b want 0", busy);
        end
        last_win = 0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int n, w, g0, d0;
        logic [N-1:0] exp_g;
        logic [7:0] exp_b;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        last_win = N - 1;
        req_data = 32'h44332211;
        g0 = gnt_cnt;
        d0 = done_cnt;
        @(posedge clk); #1 req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            w = model_pick(4'b1111, last_win);
            exp_q.push_back(req_data[8*w +: 8]);
            exp_g = '0;
            exp_g[w] = 1'b1;
            wait_start(ok, n);
            if (f == 4) req = '0;
            exp_b = exp_q.pop_front();
            checks++;
            if (!ok || (f > 0 && n != 2)) begin
                errors++;
                $display("FAIL rr_b2b_gap: frame %0d ok=%0d cycles=%0d want 2", f, ok, n);
            end
            checks++;
            if (gnt !== exp_g || byte2send !== exp_b) begin
                errors++;
                $display("FAIL rr_frame: frame %0d gnt=%b byte=%h want %b,%h", f, gnt, byte2send, exp_g, exp_b);
            end
            repeat (20) @(posedge clk);
            #1 tx_done = 1'b1;
            wait_done(ok, n);
            checks++;
            if (!ok || done !== exp_g) begin
                errors++;
                $display("FAIL rr_done: frame %0d done=%b want %b", f, done, exp_g);
            end
            @(posedge clk); #1 tx_done = 1'b0;
            last_win = w;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (gnt_cnt - g0 != 5 || done_cnt - d0 != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_counts: gnts=%0d dones=%0d busy=%b want 5,5,0", gnt_cnt - g0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int n, w;
        int order[2];
        logic [N-1:0] exp_g;
        logic [7:0] exp_b;
        order[0] = 2;
        order[1] = 0;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
        @(posedge clk); #1 req = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            w = order[k];
            exp_g = '0;
            exp_g[w] = 1'b1;
            exp_b = req_data[8*w +: 8];
            wait_start(ok, n);
            if (k == 1) req = '0;
            checks++;
            if (!ok || gnt !== exp_g || byte2send !== exp_b) begin
                errors++;
                $display("FAIL fair_order: step %0d gnt=%b byte=%h want %b,%h", k, gnt, byte2send, exp_g, exp_b);
            end
            @(posedge clk); #1 tx_done = 1'b1;
            wait_done(ok, n);
            @(posedge clk); #1 tx_done = 1'b0;
            last_win = w;
        end
    endtask

    task automatic test_handshake_edges();
        bit ok, early;
        int n, d0, g0, starts;
        logic [N-1:0] seen;
        req_data[15:8] = 8'hC3;
        g0 = gnt_cnt;
        @(posedge clk); #1 req = 4'b0010;
        wait_start(ok, n);
        req = '0;
        tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (|done !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        checks++;
        if (!ok || early) begin
            errors++;
            $display("FAIL hs_start_ignore: ok=%0d early_done_or_idle=%0d want 1,0", ok, early);
        end
        d0 = done_cnt;
        seen = '0;
        @(posedge clk); #1 tx_done = 1'b1;
        repeat (5) @(posedge clk);
        #1 tx_done = 1'b0;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) starts++;
        end
        checks++;
        if (done_cnt - d0 != 1 || gnt_cnt - g0 != 1) begin
            errors++;
            $display("FAIL hs_held_done: dones=%0d gnts=%0d want 1,1", done_cnt - d0, gnt_cnt - g0);
        end
        checks++;
        if (starts != 0 || busy !== 1'b0 || byte2send !== 8'hC3) begin
            errors++;
            $display("FAIL hs_no_retrigger: starts=%0d busy=%b byte=%h want 0,0,c3", starts, busy, byte2send);
        end
        last_win = 1;
    endtask

    task automatic test_random();
        bit ok;
        int n, w, d, wd;
        logic [N-1:0] r, exp_g;
        logic [7:0] exp_b;
        for (int f = 0; f < 24; f++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
            w = model_pick(r, last_win);
            exp_q.push_back(req_data[8*w +: 8]);
            exp_g = '0;
            exp_g[w] = 1'b1;
            @(posedge clk); #1 req = r;
            wait_start(ok, n);
            req = '0;
            exp_b = exp_q.pop_front();
            checks++;
            if (!ok || gnt !== exp_g || byte2send !== exp_b) begin
                errors++;
                $display("FAIL rand_grant: frame %0d req=%b gnt=%b byte=%h want %b,%h", f, r, gnt, byte2send, exp_g, exp_b);
            end
            for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
            d = $urandom_range(1, 25);
            repeat (d) @(posedge clk);
            #1 tx_done = 1'b1;
            wait_done(ok, n);
            checks++;
            if (!ok || n != 2 || done !== exp_g || byte2send !== exp_b) begin
                errors++;
                $display("FAIL rand_done: frame %0d cycles=%0d done=%b byte=%h want 2,%b,%h", f, n, done, byte2send, exp_g, exp_b);
            end
            wd = $urandom_range(1, 3);
            repeat (wd) @(posedge clk);
            #1 tx_done = 1'b0;
            last_win = w;
        end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, got_done;
        int n, w, d0;
        logic [N-1:0] exp_g;
        w = model_pick(4'b1000, last_win);
        d0 = done_cnt;
        @(posedge clk); #1 req = 4'b1000;
        wait_start(ok, n);
        req = '0;
        n = 0;
        got_done = 1'b0;
        while (busy === 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ok || n != 66 || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_len: cycles=%0d dones=%0d want 66,0", n, done_cnt - d0);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got %b want 1", timeout_err);
        end
        last_win = w;
        w = model_pick(4'b1001, last_win);
        exp_g = '0;
        exp_g[w] = 1'b1;
        @(posedge clk); #1 req = 4'b1001;
        wait_start(ok, n);
        req = '0;
        @(posedge clk); #1 tx_done = 1'b1;
        wait_done(got_done, n);
        @(posedge clk); #1 tx_done = 1'b0;
        checks++;
        if (!ok || !got_done || done !== exp_g || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: done=%b err=%b want %b,1", done, timeout_err, exp_g);
        end
        last_win = w;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_handshake_edges();
        test_random();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
